// File: rtl/motoro3_pwm_gen.sv
// motoro3_pwm_gen
//   Edge-aligned PWM generator for a 3-phase bridge with six-step commutation.
//   The PWM period, duty and commutation step are shadowed at each period
//   start. Each phase gets its own dead-time window whenever its drive role
//   changes.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   enable       run request; 0 forces all gates off
//   lcStep[3:0]  commutation step, 1..6 drive the bridge, anything else is safe-off
//   plLen[15:0]  PWM period in clk cycles (values below MIN_LEN are rejected)
//   pwDuty[15:0] PWM high time in clk cycles
//   pwmHi[2:0]   high-side gates {W,V,U}
//   pwmLo[2:0]   low-side gates {W,V,U}
//   periodStart  one-cycle pulse on the cnt==0 cycle of every period
//   lenErr       one-cycle pulse when a period reload is rejected
module motoro3_pwm_gen #(
  parameter int DEAD_CYC = 8,
  parameter int MIN_LEN  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  lcStep,
  input  logic [15:0] plLen,
  input  logic [15:0] pwDuty,
  output logic [2:0]  pwmHi,
  output logic [2:0]  pwmLo,
  output logic        periodStart,
  output logic        lenErr
);

  localparam int DW = $clog2(DEAD_CYC + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  // Drive role of a single phase
  typedef enum logic [1:0] {DRV_OFF = 2'd0, DRV_HI = 2'd1, DRV_LO = 2'd2} drv_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] len_sh_q, len_sh_d;
  logic [15:0] duty_sh_q, duty_sh_d;
  logic [3:0]  step_sh_q, step_sh_d;
  logic        period_start_q, period_start_d;
  logic        len_err_q, len_err_d;
  logic [2:0]  pwm_hi_q, pwm_hi_d;
  logic [2:0]  pwm_lo_q, pwm_lo_d;
  drv_t        req_q [3];
  drv_t        req_d [3];
  drv_t        req_s [3];
  logic [DW-1:0] dead_q [3];
  logic [DW-1:0] dead_d [3];

  logic        len_ok_s;
  logic [15:0] duty_clip_s;
  logic        run_s;
  logic        pwm_on_s;

  // Reload qualification and duty clipping against the incoming period
  always_comb begin
    len_ok_s    = (plLen >= 16'(MIN_LEN));
    duty_clip_s = (pwDuty < plLen) ? pwDuty : plLen;
  end

  // Period sequencer: state, counter, shadows and status pulses
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    len_sh_d       = len_sh_q;
    duty_sh_d      = duty_sh_q;
    step_sh_d      = step_sh_q;
    period_start_d = 1'b0;
    len_err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (enable) begin
          if (len_ok_s) begin
            len_sh_d       = plLen;
            duty_sh_d      = duty_clip_s;
            step_sh_d      = lcStep;
            period_start_d = 1'b1;
            state_d        = RUN;
          end else begin
            len_err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Dropping enable beats a coincident reload
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end else if (cnt_q == (len_sh_q - 16'd1)) begin
          cnt_d          = 16'd0;
          period_start_d = 1'b1;
          if (len_ok_s) begin
            len_sh_d  = plLen;
            duty_sh_d = duty_clip_s;
            step_sh_d = lcStep;
          end else begin
            // Rejected reload: old shadows stay, period restarts anyway
            len_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Commutation decode: role of each phase from the shadowed step
  always_comb begin
    run_s    = (state_q == RUN) && enable;
    pwm_on_s = (cnt_q < duty_sh_q);
    for (int i = 0; i < 3; i++) begin
      req_s[i] = DRV_OFF;
    end
    if (run_s) begin
      case (step_sh_q)
        4'd1: begin req_s[0] = DRV_HI; req_s[1] = DRV_LO; end
        4'd2: begin req_s[0] = DRV_HI; req_s[2] = DRV_LO; end
        4'd3: begin req_s[1] = DRV_HI; req_s[2] = DRV_LO; end
        4'd4: begin req_s[1] = DRV_HI; req_s[0] = DRV_LO; end
        4'd5: begin req_s[2] = DRV_HI; req_s[0] = DRV_LO; end
        4'd6: begin req_s[2] = DRV_HI; req_s[1] = DRV_LO; end
        default: begin
          // Illegal steps are a silent safe-off
          req_s[0] = DRV_OFF;
        end
      endcase
    end else begin
      req_s[0] = DRV_OFF;
    end
  end

  // Per-phase dead time; hi and lo derive from one role so they are exclusive
  always_comb begin
    pwm_hi_d = 3'b000;
    pwm_lo_d = 3'b000;
    for (int i = 0; i < 3; i++) begin
      req_d[i]  = req_s[i];
      dead_d[i] = dead_q[i];
      if (req_s[i] != req_q[i]) begin
        // Going off needs no wait; any other change (re)opens the window
        if (req_s[i] == DRV_OFF) begin
          dead_d[i] = '0;
        end else begin
          dead_d[i] = DW'(DEAD_CYC - 1);
        end
      end else if (dead_q[i] != '0) begin
        dead_d[i] = dead_q[i] - {{(DW-1){1'b0}}, 1'b1};
      end else begin
        pwm_hi_d[i] = (req_s[i] == DRV_HI) && pwm_on_s;
        pwm_lo_d[i] = (req_s[i] == DRV_LO);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 16'd0;
      len_sh_q       <= 16'd0;
      duty_sh_q      <= 16'd0;
      step_sh_q      <= 4'd0;
      period_start_q <= 1'b0;
      len_err_q      <= 1'b0;
      pwm_hi_q       <= 3'b000;
      pwm_lo_q       <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        req_q[i]  <= DRV_OFF;
        dead_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      len_sh_q       <= len_sh_d;
      duty_sh_q      <= duty_sh_d;
      step_sh_q      <= step_sh_d;
      period_start_q <= period_start_d;
      len_err_q      <= len_err_d;
      pwm_hi_q       <= pwm_hi_d;
      pwm_lo_q       <= pwm_lo_d;
      for (int i = 0; i < 3; i++) begin
        req_q[i]  <= req_d[i];
        dead_q[i] <= dead_d[i];
      end
    end
  end

  assign pwmHi       = pwm_hi_q;
  assign pwmLo       = pwm_lo_q;
  assign periodStart = period_start_q;
  assign lenErr      = len_err_q;

endmodule
